// File: rtl/matvec_param_seq.sv
// Sequential KxK signed matrix-vector multiplier with a stored, reusable matrix and valid/ready streams.
// Optional build macro MATVEC_RELU_EN clamps negative results to zero.
module matvec_param_seq #(
    parameter int unsigned K     = 8,
    parameter int unsigned IN_W  = 14,
    parameter int unsigned OUT_W = 2 * IN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [IN_W-1:0]  input_data,
    input  logic             new_matrix,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [OUT_W-1:0] output_data
);

    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PW = 2 * IN_W;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_M,
        S_LOAD_X,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    row_q, col_q;
    logic [IN_W-1:0]  m_q [K][K];
    logic [IN_W-1:0]  x_q [K];
    logic [OUT_W-1:0] acc_q;

    logic              accept_c;
    logic              row_last_c, col_last_c;
    logic signed [PW-1:0] prod_c;
    logic [OUT_W-1:0]  acc_sum_c, result_c;

    assign accept_c   = input_valid & input_ready;
    assign row_last_c = (row_q == LAST);
    assign col_last_c = (col_q == LAST);

    // Single MAC: column 0 restarts the accumulator instead of adding to it
    assign prod_c    = PW'($signed(m_q[row_q][col_q])) * PW'($signed(x_q[col_q]));
    assign acc_sum_c = ((col_q == '0) ? '0 : acc_q) + OUT_W'(prod_c);

`ifdef MATVEC_RELU_EN
    assign result_c = acc_sum_c[OUT_W-1] ? '0 : acc_sum_c;
`else
    assign result_c = acc_sum_c;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept_c) state_d = new_matrix ? S_LOAD_M : S_LOAD_X;
            S_LOAD_M:  if (accept_c && row_last_c && col_last_c) state_d = S_LOAD_X;
            S_LOAD_X:  if (accept_c && col_last_c) state_d = S_COMPUTE;
            S_COMPUTE: if (col_last_c) state_d = S_OUTPUT;
            S_OUTPUT:  if (output_ready) state_d = row_last_c ? S_IDLE : S_COMPUTE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Handshake flags follow the next state so they line up with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            input_ready  <= 1'b0;
            output_valid <= 1'b0;
        end else begin
            input_ready  <= (state_d == S_IDLE) || (state_d == S_LOAD_M) || (state_d == S_LOAD_X);
            output_valid <= (state_d == S_OUTPUT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q       <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            output_data <= '0;
            for (int i = 0; i < int'(K); i++) begin
                x_q[i] <= '0;
                for (int j = 0; j < int'(K); j++) m_q[i][j] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        row_q <= '0;
                        col_q <= CW'(1);
                        if (new_matrix) m_q[0][0] <= input_data;
                        else            x_q[0]    <= input_data;
                    end
                end
                S_LOAD_M: begin
                    if (accept_c) begin
                        m_q[row_q][col_q] <= input_data;
                        if (col_last_c) begin
                            col_q <= '0;
                            row_q <= row_last_c ? '0 : row_q + CW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                S_LOAD_X: begin
                    if (accept_c) begin
                        x_q[col_q] <= input_data;
                        col_q      <= col_last_c ? '0 : col_q + CW'(1);
                    end
                end
                S_COMPUTE: begin
                    acc_q <= acc_sum_c;
                    if (col_last_c) begin
                        col_q       <= '0;
                        output_data <= result_c;
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (output_ready) row_q <= row_last_c ? '0 : row_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_param_seq.sv
// Randomized bench for matvec_param_seq: a K=2 and a K=8 instance checked against an arithmetic model.
`timescale 1ns/1ps
module tb_matvec_param_seq;

    localparam int unsigned IN_W  = 14;
    localparam int unsigned OUT_W = 28;

    logic clk = 1'b0;
    logic reset;
    logic             in_valid  [2];
    logic             in_ready  [2];
    logic             new_mat   [2];
    logic             out_valid [2];
    logic             out_ready [2];
    logic [IN_W-1:0]  in_data   [2];
    logic [OUT_W-1:0] out_data  [2];

    int n_tests = 0;
    int n_fail  = 0;

    int m_ref [2][8][8];
    int x_ref [2][8];
    int mat_buf [8][8];
    int vec_buf [8];
    logic [OUT_W-1:0] exp_y [8];

    always #5 clk = ~clk;

    matvec_param_seq #(.K(2), .IN_W(IN_W), .OUT_W(OUT_W)) u_dut2 (
        .clk(clk), .reset(reset),
        .input_valid(in_valid[0]), .input_ready(in_ready[0]),
        .input_data(in_data[0]), .new_matrix(new_mat[0]),
        .output_valid(out_valid[0]), .output_ready(out_ready[0]),
        .output_data(out_data[0])
    );

    matvec_param_seq #(.K(8), .IN_W(IN_W), .OUT_W(OUT_W)) u_dut8 (
        .clk(clk), .reset(reset),
        .input_valid(in_valid[1]), .input_ready(in_ready[1]),
        .input_data(in_data[1]), .new_matrix(new_mat[1]),
        .output_valid(out_valid[1]), .output_ready(out_ready[1]),
        .output_data(out_data[1])
    );

    function automatic int kdim(input int sel);
        return (sel == 0) ? 2 : 8;
    endfunction

    function automatic int rand_s14();
        logic [13:0] v;
        v = 14'($urandom);
        return int'($signed(v));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // y = M*x with plain integer arithmetic, then wrap to OUT_W bits
    task automatic compute_exp(input int sel);
        int k;
        longint s;
        k = kdim(sel);
        for (int r = 0; r < k; r++) begin
            s = 0;
            for (int c = 0; c < k; c++)
                s += longint'(m_ref[sel][r][c]) * longint'(x_ref[sel][c]);
            exp_y[r] = OUT_W'(s);
`ifdef MATVEC_RELU_EN
            if (exp_y[r][OUT_W-1]) exp_y[r] = '0;
`endif
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 8; r++) begin
                x_ref[s][r] = 0;
                for (int c = 0; c < 8; c++) m_ref[s][r][c] = 0;
            end
    endtask

    task automatic send_word(input int sel, input logic [IN_W-1:0] d, input logic nm);
        int guard;
        guard = 0;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        in_valid[sel] = 1'b1;
        in_data[sel]  = d;
        new_mat[sel]  = nm;
        while (!in_ready[sel] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            check("send_timeout", 64'(guard), 64'(0));
            in_valid[sel] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        in_data[sel]  = 14'($urandom);
        new_mat[sel]  = 1'($urandom);
    endtask

    // mode 0: random back-pressure, 1: always ready, 2: stall the first result 10 cycles
    task automatic recv_rows(input int sel, input int n, input int mode);
        int guard;
        bit got;
        logic [OUT_W-1:0] held;
        for (int r = 0; r < n; r++) begin
            guard = 0;
            got   = 1'b0;
            while (!got && guard < 300) begin
                @(negedge clk);
                if (out_valid[sel]) begin
                    if (mode == 2 && r == 0) begin
                        held = out_data[sel];
                        out_ready[sel] = 1'b0;
                        for (int h = 0; h < 10; h++) begin
                            @(negedge clk);
                            check("stall_valid", 64'(out_valid[sel]), 64'(1));
                            check("stall_data", 64'(out_data[sel]), 64'(held));
                            check("stall_in_ready", 64'(in_ready[sel]), 64'(0));
                        end
                    end
                    out_ready[sel] = (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
                    got = out_ready[sel];
                end else begin
                    out_ready[sel] = 1'($urandom);
                end
                guard++;
            end
            if (!got) begin
                check("rx_timeout", 64'(0), 64'(1));
                return;
            end
            check($sformatf("y%0d_k%0d", r, kdim(sel)), 64'(out_data[sel]), 64'(exp_y[r]));
            @(posedge clk);
            #1;
            out_ready[sel] = 1'b0;
        end
    endtask

    task automatic do_txn(input int sel, input bit nm, input bit lat, input int mode);
        int k;
        int n;
        k = kdim(sel);
        if (nm)
            for (int i = 0; i < k * k; i++)
                send_word(sel, 14'(mat_buf[i / k][i % k]), (i == 0) ? 1'b1 : 1'($urandom));
        for (int i = 0; i < k; i++)
            send_word(sel, 14'(vec_buf[i]), (i == 0 && !nm) ? 1'b0 : 1'($urandom));
        if (nm)
            for (int r = 0; r < k; r++)
                for (int c = 0; c < k; c++) m_ref[sel][r][c] = mat_buf[r][c];
        for (int c = 0; c < k; c++) x_ref[sel][c] = vec_buf[c];
        compute_exp(sel);
        if (lat) begin
            out_ready[sel] = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid[sel] && n < 100);
            check("first_valid_latency", 64'(n - 1), 64'(k));
        end
        recv_rows(sel, k, mode);
        @(negedge clk);
        check("no_extra_result", 64'(out_valid[sel]), 64'(0));
    endtask

    task automatic fill_random(input int sel);
        for (int r = 0; r < kdim(sel); r++) begin
            vec_buf[r] = rand_s14();
            for (int c = 0; c < kdim(sel); c++) mat_buf[r][c] = rand_s14();
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0; in_data[s] = '0; new_mat[s] = 1'b0; out_ready[s] = 1'b0;
        end
        clear_model();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_in_ready", 64'(in_ready[s]), 64'(0));
            check("reset_out_valid", 64'(out_valid[s]), 64'(0));
            check("reset_out_data", 64'(out_data[s]), 64'(0));
        end
        reset = 1'b1;

        // vector before any matrix: zero matrix gives zero results
        fill_random(0);
        do_txn(0, 1'b0, 1'b0, 0);

        mat_buf[0][0] = 1; mat_buf[0][1] = 2; mat_buf[1][0] = 3; mat_buf[1][1] = 4;
        vec_buf[0] = 5; vec_buf[1] = 6;
        do_txn(0, 1'b1, 1'b0, 1);
        check("directed_17_39", {36'd0, exp_y[0]}, 64'(17));

        vec_buf[0] = -1; vec_buf[1] = 1;
        do_txn(0, 1'b0, 1'b0, 1);

        mat_buf[0][0] = -1; mat_buf[0][1] = 0; mat_buf[1][0] = 0; mat_buf[1][1] = 1;
        vec_buf[0] = 3; vec_buf[1] = 3;
        do_txn(0, 1'b1, 1'b0, 0);

        fill_random(0);
        do_txn(0, 1'b1, 1'b0, 2);

        for (int r = 0; r < 8; r++) begin
            vec_buf[r] = -8192;
            for (int c = 0; c < 8; c++) mat_buf[r][c] = -8192;
        end
        do_txn(1, 1'b1, 1'b1, 1);

        for (int t = 0; t < 12; t++) begin
            int sel;
            sel = int'($urandom_range(0, 1));
            fill_random(sel);
            do_txn(sel, (t < 2) ? 1'b1 : 1'($urandom), 1'b0, 0);
        end

        // abort during row 3 compute
        fill_random(1);
        do_txn(1, 1'b1, 1'b0, 1);
        fill_random(1);
        for (int i = 0; i < 8; i++)
            send_word(1, 14'(vec_buf[i]), (i == 0) ? 1'b0 : 1'($urandom));
        for (int c = 0; c < 8; c++) x_ref[1][c] = vec_buf[c];
        compute_exp(1);
        recv_rows(1, 3, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid[1]), 64'(0));
        check("abort_in_ready", 64'(in_ready[1]), 64'(0));
        check("abort_out_data", 64'(out_data[1]), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_model();

        fill_random(1);
        do_txn(1, 1'b0, 1'b0, 0);
        fill_random(0);
        do_txn(0, 1'b0, 1'b0, 0);
        fill_random(1);
        do_txn(1, 1'b1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
